// File: rtl/sram_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_wb_ctrl_if
// Wishbone classic bus bundle between the system interconnect (master) and
// the SRAM controller (slave).
//   adr    : byte address, master -> slave
//   sel    : byte lane enables, master -> slave
//   we     : write enable, master -> slave
//   wr_dat : write data, master -> slave
//   rd_dat : read data, slave -> master
//   cyc    : bus cycle, master -> slave
//   stb    : strobe, master -> slave
//   ack    : single-cycle acknowledge, slave -> master
//   err    : error (always 0), slave -> master
// ---------------------------------------------------------------------------
interface sram_wb_ctrl_if;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wr_dat;
    logic [31:0] rd_dat;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output adr, sel, we, wr_dat, cyc, stb,
        input  rd_dat, ack, err
    );

    modport slave (
        input  adr, sel, we, wr_dat, cyc, stb,
        output rd_dat, ack, err
    );
endinterface

// File: rtl/sram_wb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_wb_ctrl
// Wishbone classic slave sequencing a 4 x 2Mx8 asynchronous SRAM bank.
// Each 32-bit access is split into one SRAM cycle per selected byte lane,
// lowest lane first: SETUP (1) -> STROBE (WAIT_CYCLES) -> HOLD (HOLD_CYCLES).
//
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   wb               : Wishbone slave bundle (sram_wb_ctrl_if.slave)
//   o_sram_cs        : one-hot chip select from adr[22:21], active-high
//   o_sram_read      : output enable, active-high
//   o_sram_write     : write strobe, active-high
//   o_sram_addr      : SRAM byte address {adr[20:2], lane}
//   io_sram_data     : bidirectional SRAM data bus
//   o_busy           : high whenever the FSM is not in IDLE
//
// Parameters:
//   WAIT_CYCLES : cycles the read/write strobe is held per byte (min 1)
//   HOLD_CYCLES : cycles address/CS/write data are held after it (min 1)
//
// Build option:
//   SRAM_WR_POSTED_EN : when defined, writes are acknowledged on acceptance
//                       and their SRAM sequence runs in the background.
// ---------------------------------------------------------------------------
module sram_wb_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    sram_wb_ctrl_if.slave wb,
    output logic [3:0]    o_sram_cs,
    output logic          o_sram_read,
    output logic          o_sram_write,
    output logic [20:0]   o_sram_addr,
    inout  wire  [7:0]    io_sram_data,
    output logic          o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ACK
    } state_t;

    state_t      state;
    logic [18:0] word_adr;
    logic [3:0]  pending;
    logic [3:0]  remaining;
    logic [1:0]  lane;
    logic        is_write;
    logic [31:0] wr_buf;
    logic [31:0] rd_buf;
    logic [7:0]  wr_byte;
    logic        data_oe;
    logic [7:0]  cnt;
`ifdef SRAM_WR_POSTED_EN
    logic        posted;
`endif

    // Address bits outside the chip/word fields are decoded by the interconnect.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb.adr[31:23], wb.adr[1:0]};

    // Lowest set bit of a lane mask; lanes are served in ascending order.
    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        if (mask[0])      first_lane = 2'd0;
        else if (mask[1]) first_lane = 2'd1;
        else if (mask[2]) first_lane = 2'd2;
        else              first_lane = 2'd3;
    endfunction

    assign remaining    = pending & ~(4'b0001 << lane);
    assign o_busy       = (state != IDLE);
    assign wb.err       = 1'b0;
    // The bus is driven only by write sequences; data_oe is never set for reads.
    assign io_sram_data = data_oe ? wr_byte : 8'bz;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            word_adr     <= '0;
            pending      <= '0;
            lane         <= '0;
            is_write     <= 1'b0;
            wr_buf       <= '0;
            rd_buf       <= '0;
            wr_byte      <= '0;
            data_oe      <= 1'b0;
            cnt          <= '0;
            o_sram_cs    <= '0;
            o_sram_read  <= 1'b0;
            o_sram_write <= 1'b0;
            o_sram_addr  <= '0;
            wb.ack       <= 1'b0;
            wb.rd_dat    <= '0;
`ifdef SRAM_WR_POSTED_EN
            posted       <= 1'b0;
`endif
        end else begin
            wb.ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb.cyc && wb.stb) begin
                        word_adr <= wb.adr[20:2];
                        is_write <= wb.we;
                        wr_buf   <= wb.wr_dat;
                        rd_buf   <= '0;
                        pending  <= wb.sel;
`ifdef SRAM_WR_POSTED_EN
                        posted   <= wb.we;
                        if (wb.we) wb.ack <= 1'b1;
`endif
                        if (wb.sel == 4'b0000) begin
                            state  <= ACK;
                            wb.ack <= 1'b1;
                            if (!wb.we) wb.rd_dat <= '0;
                        end else begin
                            lane        <= first_lane(wb.sel);
                            o_sram_cs   <= 4'b0001 << wb.adr[22:21];
                            o_sram_addr <= {wb.adr[20:2], first_lane(wb.sel)};
                            wr_byte     <= wb.wr_dat[{first_lane(wb.sel), 3'b000} +: 8];
                            data_oe     <= wb.we;
                            state       <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    cnt          <= '0;
                    o_sram_read  <= !is_write;
                    o_sram_write <= is_write;
                    state        <= STROBE;
                end

                // Read data is sampled on the edge that ends the last strobe
                // cycle, while the SRAM is still driving the bus.
                STROBE: begin
                    if (cnt == 8'(WAIT_CYCLES - 1)) begin
                        o_sram_read  <= 1'b0;
                        o_sram_write <= 1'b0;
                        if (!is_write) rd_buf[{lane, 3'b000} +: 8] <= io_sram_data;
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                // CS stays asserted between lanes; only address and data move.
                HOLD: begin
                    if (cnt == 8'(HOLD_CYCLES - 1)) begin
                        pending <= remaining;
                        if (remaining != 4'b0000) begin
                            lane        <= first_lane(remaining);
                            o_sram_addr <= {word_adr, first_lane(remaining)};
                            wr_byte     <= wr_buf[{first_lane(remaining), 3'b000} +: 8];
                            state       <= SETUP;
                        end else begin
                            o_sram_cs <= '0;
                            data_oe   <= 1'b0;
                            if (!is_write) wb.rd_dat <= rd_buf;
`ifdef SRAM_WR_POSTED_EN
                            if (posted) begin
                                state <= IDLE;
                            end else begin
                                state  <= ACK;
                                wb.ack <= 1'b1;
                            end
`else
                            state  <= ACK;
                            wb.ack <= 1'b1;
`endif
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                ACK: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_wb_ctrl
// Self-checking bench for sram_wb_ctrl with a behavioural 8 MB SRAM model.
// Expected SRAM strobes and Wishbone acks are queued when an access is
// driven and popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_sram_wb_ctrl;

    localparam int WAIT = 2;
    localparam int HOLD = 1;
    localparam int T    = 1 + WAIT + HOLD;
`ifdef SRAM_WR_POSTED_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [3:0]  cs;
        logic [20:0] addr;
        logic [7:0]  data;
        int          len;
    } strobe_t;

    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic        we;
    } ack_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  cs;
    logic        rd;
    logic        wr;
    logic [20:0] addr;
    logic        busy;
    wire  [7:0]  sram_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    strobe_t strobe_q[$];
    ack_t    ack_q[$];
    bit      ignore_strobes = 1'b0;

    logic [7:0] mem [logic [22:0]];
    logic [7:0] mem_rd_byte = 8'h00;

    sram_wb_ctrl_if wb_bus ();

    sram_wb_ctrl #(
        .WAIT_CYCLES (WAIT),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .wb           (wb_bus.slave),
        .o_sram_cs    (cs),
        .o_sram_read  (rd),
        .o_sram_write (wr),
        .o_sram_addr  (addr),
        .io_sram_data (sram_data),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [22:0] mkey(input logic [3:0] c, input logic [20:0] a);
        case (c)
            4'b0001: mkey = {2'd0, a};
            4'b0010: mkey = {2'd1, a};
            4'b0100: mkey = {2'd2, a};
            default: mkey = {2'd3, a};
        endcase
    endfunction

    // SRAM model read path: the byte is looked up while OE is high.
    assign sram_data = rd ? mem_rd_byte : 8'bz;

    always @(negedge clk) begin
        if (rd) mem_rd_byte = mem.exists(mkey(cs, addr)) ? mem[mkey(cs, addr)] : 8'h00;
    end

    // Strobe monitor: collects each contiguous read/write strobe run,
    // checks it against the queue and commits writes to the memory model.
    int          run_len = 0;
    logic        run_we;
    logic [3:0]  run_cs;
    logic [20:0] run_addr;
    logic [7:0]  run_data;
    strobe_t     mon_s;

    always @(negedge clk) begin
        if (rd) begin
            n_cmp++;
            if (dut.data_oe !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL contention: data_oe=%b while o_sram_read=1 expected 0", dut.data_oe);
            end
        end
        if (rd || wr) begin
            if (run_len == 0) begin
                run_we   = wr;
                run_cs   = cs;
                run_addr = addr;
                run_data = sram_data;
            end
            run_len++;
        end else if (run_len > 0) begin
            if (!ignore_strobes) begin
                n_cmp++;
                if (strobe_q.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL unexpected_strobe: we=%b cs=%b addr=%h expected none",
                             run_we, run_cs, run_addr);
                end else begin
                    mon_s = strobe_q.pop_front();
                    if (run_we !== mon_s.we || run_cs !== mon_s.cs || run_addr !== mon_s.addr ||
                        run_len != mon_s.len || (mon_s.we && run_data !== mon_s.data)) begin
                        n_err++;
                        $display("[TB] FAIL strobe: got we=%b cs=%b addr=%h data=%h len=%0d expected we=%b cs=%b addr=%h data=%h len=%0d",
                                 run_we, run_cs, run_addr, run_data, run_len,
                                 mon_s.we, mon_s.cs, mon_s.addr, mon_s.data, mon_s.len);
                    end
                end
            end
            if (run_we) mem[mkey(run_cs, run_addr)] = run_data;
            run_len = 0;
        end
    end

    // Runs one Wishbone access. exp_edge < 0 skips the latency and CS checks.
    task automatic do_access(input string name, input logic [31:0] adr, input logic [3:0] sel,
                             input logic we, input logic [31:0] dat, input int exp_edge,
                             input logic [31:0] exp_rd, output int ack_cyc);
        logic [3:0] exp_cs;
        logic       posted_wr;
        int         k;
        int         cs_bad;
        bit         got;
        ack_t       e;
        exp_cs    = 4'b0001 << adr[22:21];
        posted_wr = POSTED && we;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) strobe_q.push_back('{we: we, cs: exp_cs, addr: {adr[20:2], 2'(n)},
                                             data: dat[8*n +: 8], len: WAIT});
        end
        ack_q.push_back('{lat: exp_edge, rd: exp_rd, we: we});

        @(negedge clk);
        wb_bus.adr    = adr;
        wb_bus.sel    = sel;
        wb_bus.we     = we;
        wb_bus.wr_dat = dat;
        wb_bus.cyc    = 1'b1;
        wb_bus.stb    = 1'b1;
        @(posedge clk);
        k = 0; cs_bad = 0; got = 1'b0; ack_cyc = 0;
        while (!got && k < 300) begin
            @(negedge clk);
            if (wb_bus.ack) begin
                got = 1'b1;
            end else begin
                if (exp_edge >= 0 && ((sel == 4'b0000 && cs !== 4'b0000) ||
                                      (sel != 4'b0000 && cs !== exp_cs))) cs_bad++;
                @(posedge clk);
                k++;
            end
        end
        wb_bus.cyc = 1'b0;
        wb_bus.stb = 1'b0;
        wb_bus.we  = 1'b0;
        e = ack_q.pop_front();
        if (!got) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL %s_timeout: no ack after %0d cycles, expected ack at edge %0d", name, k, e.lat);
            return;
        end
        ack_cyc = cyc_cnt;
        if (e.lat >= 0) begin
            n_cmp++;
            if (k != e.lat) begin
                n_err++;
                $display("[TB] FAIL %s_latency: ack at edge %0d expected %0d", name, k, e.lat);
            end
            n_cmp++;
            if (cs_bad != 0) begin
                n_err++;
                $display("[TB] FAIL %s_cs: %0d cycles with wrong cs expected 0 (cs=%b)", name, cs_bad, exp_cs);
            end
        end
        if (!e.we) begin
            n_cmp++;
            if (wb_bus.rd_dat !== e.rd) begin
                n_err++;
                $display("[TB] FAIL %s_rdata: got %h expected %h", name, wb_bus.rd_dat, e.rd);
            end
        end
        if (!posted_wr) begin
            n_cmp++;
            if (cs !== 4'b0000) begin
                n_err++;
                $display("[TB] FAIL %s_cs_in_ack: got %b expected 0000", name, cs);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (wb_bus.ack !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL %s_ack_width: ack still %b one cycle later expected 0", name, wb_bus.ack);
        end
    endtask

    // Waits for the background sequence to finish and every strobe to be seen.
    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || strobe_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL %s_drain: busy=%b pending_strobes=%0d expected busy=0 pending=0",
                     name, busy, strobe_q.size());
        end
    endtask

    task automatic test_reset();
        int k;
        wb_bus.adr = '0; wb_bus.sel = '0; wb_bus.we = 1'b0; wb_bus.wr_dat = '0;
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs, rd, wr, addr, wb_bus.ack, wb_bus.err, busy, dut.data_oe} !== '0 ||
            wb_bus.rd_dat !== 32'h0) begin
            n_err++;
            $display("[TB] FAIL reset_outputs: cs=%b rd=%b wr=%b addr=%h ack=%b err=%b busy=%b oe=%b rdat=%h expected all 0",
                     cs, rd, wr, addr, wb_bus.ack, wb_bus.err, busy, dut.data_oe, wb_bus.rd_dat);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Abort a write in the middle of its strobe.
        ignore_strobes = 1'b1;
        wb_bus.adr = 32'h0040_0008; wb_bus.sel = 4'b1111; wb_bus.we = 1'b1;
        wb_bus.wr_dat = 32'hDEAD_BEEF; wb_bus.cyc = 1'b1; wb_bus.stb = 1'b1;
        k = 0;
        while (!wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!wr) begin
            n_err++;
            $display("[TB] FAIL reset_no_strobe: o_sram_write=%b expected 1 before reset", wr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wr !== 1'b0 || cs !== 4'b0000 || wb_bus.ack !== 1'b0 || dut.data_oe !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_async: wr=%b cs=%b ack=%b oe=%b expected 0 0000 0 0",
                     wr, cs, wb_bus.ack, dut.data_oe);
        end
        wb_bus.cyc = 1'b0; wb_bus.stb = 1'b0; wb_bus.we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || wr !== 1'b0 || cs !== 4'b0000 || wb_bus.ack !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_release: busy=%b wr=%b cs=%b ack=%b expected 0 0 0000 0",
                     busy, wr, cs, wb_bus.ack);
        end
        ignore_strobes = 1'b0;
    endtask

    task automatic test_full_write();
        int c;
        do_access("full_write", 32'h0040_0008, 4'b1111, 1'b1, 32'hA1B2_C3D4,
                  POSTED ? 0 : 4 * T, 32'h0, c);
        wait_drain("full_write");
    endtask

    task automatic test_full_read();
        int c;
        do_access("full_read", 32'h0040_0008, 4'b1111, 1'b0, 32'h0, 4 * T, 32'hA1B2_C3D4, c);
        wait_drain("full_read");
    endtask

    task automatic test_partial();
        int c;
        do_access("partial_write", 32'h0000_0000, 4'b0100, 1'b1, 32'h00EE_0000,
                  POSTED ? 0 : T, 32'h0, c);
        wait_drain("partial_write");
        n_cmp++;
        if (wb_bus.rd_dat !== 32'hA1B2_C3D4) begin
            n_err++;
            $display("[TB] FAIL rdata_hold: got %h expected %h", wb_bus.rd_dat, 32'hA1B2_C3D4);
        end
        do_access("partial_read", 32'h0000_0000, 4'b0110, 1'b0, 32'h0, 2 * T, 32'h00EE_5A00, c);
        wait_drain("partial_read");
    endtask

    task automatic test_empty_select();
        int c;
        do_access("empty_read", 32'h0060_0004, 4'b0000, 1'b0, 32'h0, 0, 32'h0, c);
        wait_drain("empty_read");
        do_access("empty_write", 32'h0060_0004, 4'b0000, 1'b1, 32'hFFFF_FFFF, 0, 32'h0, c);
        wait_drain("empty_write");
    endtask

`ifdef SRAM_WR_POSTED_EN
    task automatic test_posted();
        int cw;
        int cr;
        do_access("posted_write", 32'h0020_0010, 4'b1111, 1'b1, 32'h1122_3344, 0, 32'h0, cw);
        do_access("posted_read", 32'h0020_0010, 4'b1111, 1'b0, 32'h0, -1, 32'h1122_3344, cr);
        n_cmp++;
        if (cr - cw != 4 * T + 1 + 4 * T) begin
            n_err++;
            $display("[TB] FAIL posted_order_latency: read ack %0d cycles after write ack expected %0d",
                     cr - cw, 4 * T + 1 + 4 * T);
        end
        wait_drain("posted");
    endtask
`endif

    initial begin
        mem[{2'd0, 21'd1}] = 8'h5A;
        test_reset();
        test_full_write();
        test_full_read();
        test_partial();
        test_empty_select();
`ifdef SRAM_WR_POSTED_EN
        test_posted();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_wb_ctrl.md
Name: sram_wb_ctrl

Overview:
- Wishbone classic slave that sequences the external 2Mx8 asynchronous SRAM bank: 4 chips, 8 MB total, 8-bit data.
- Splits each 32-bit Wishbone access into per-byte SRAM cycles, with programmable setup, strobe and hold timing.
- Sits between the system Wishbone interconnect and the SRAM pins.
- SRAM strobes are driven active-high; the top level inverts them to the pad polarity.

Parameters:
- WAIT_CYCLES, 2, clock cycles o_sram_read/o_sram_write stay asserted per byte (min 1).
- HOLD_CYCLES, 1, clock cycles after the strobe with address, CS and write data held stable (min 1).

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_wb_adr  in  32  byte address; bits [22:21] select chip, [20:2] word
- i_wb_sel  in  4  byte lane enables
- i_wb_we  in  1  write enable
- i_wb_dat  in  32  write data
- o_wb_dat  out  32  read data
- i_wb_cyc  in  1  bus cycle
- i_wb_stb  in  1  strobe
- o_wb_ack  out  1  single-cycle acknowledge
- o_wb_err  out  1  tied 0
- o_sram_cs  out  4  one-hot chip select, active-high
- o_sram_read  out  1  output enable, active-high
- o_sram_write  out  1  write strobe, active-high
- o_sram_addr  out  21  SRAM byte address
- io_sram_data  inout  8  SRAM data bus
- o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset state: all outputs 0; io_sram_data released (Z); state IDLE; internal registers cleared.
- Reset mid-operation: sequence aborts immediately; no ack is issued; strobes drop asynchronously.
- Byte lane mapping (little-endian): lane n ↔ wb_dat[8n+7:8n] ↔ o_sram_addr = {adr[20:2], n[1:0]}.
- Chip select: o_sram_cs = 1 << adr[22:21]. Address bits above 22 are ignored (decoding is done by the interconnect).
- IDLE:
  - On i_wb_cyc & i_wb_stb (the accept edge, edge 0), latch adr, sel, we and dat.
  - If sel == 0, go to ACK.
  - Otherwise go to SETUP with the lowest set lane.
- SETUP (1 cycle): cs and addr driven; read/write low. For writes, io_sram_data is driven with the lane byte.
- STROBE (WAIT_CYCLES cycles): o_sram_read or o_sram_write high. For reads, io_sram_data is registered into lane n on the edge ending the last strobe cycle.
- HOLD (HOLD_CYCLES cycles): strobes low; cs, addr and write data held.
  - Then go to SETUP for the next set lane (ascending order), else ACK.
  - cs stays asserted across all bytes of one transaction.
- ACK (1 cycle): o_wb_ack=1; cs low; data bus released. Next state IDLE, and no re-accept is possible in the ACK cycle.
- Latency: with N set lanes and T = 1+WAIT_CYCLES+HOLD_CYCLES, o_wb_ack is high for exactly the cycle beginning at edge N*T after the accept edge (sel=0 gives the cycle after edge 0).
- Read data: o_wb_dat is valid while ack is high. Unselected lanes read 0x00. o_wb_dat holds its value until the next read completes.
- Bus contention: io_sram_data is driven only in SETUP/STROBE/HOLD of a write, never while o_sram_read=1.
- Deassertion: i_wb_stb dropped by the master mid-sequence does not abort; the sequence completes and the ack is dropped by the master.

Optional Feature:
- Macro: SRAM_WR_POSTED_EN.
- Defined:
  - A write accepted in IDLE is acked in the cycle after edge 0; its SRAM sequence runs in the background (o_busy=1).
  - A new request arriving while busy is not latched until the current sequence reaches IDLE. Ordering is preserved, so a read after a posted write returns the new data.
  - A posted write issued while busy is acked only when accepted.
- Undefined: writes are acked only after the last byte's HOLD, per the latency rule above.

Test Plan:
- Reset: assert i_reset_n=0 during STROBE of a write → o_sram_write, o_sram_cs and o_wb_ack drop to 0 at once, data bus Z; after release, state IDLE, o_busy=0.
- Full word write: adr=0x0040_0008, sel=4'b1111, dat=0xA1B2C3D4, W=2, H=1 → cs=4'b0100; bytes D4, C3, B2, A1 at addr 0x08–0x0B; each write strobe is 2 cycles; ack at edge 16.
- Full word read: same address as the write test → o_wb_dat=0xA1B2C3D4 with ack at edge 16; o_sram_read never overlaps data drive.
- Partial access: write sel=4'b0100, dat=0x00EE0000 to 0x0000_0000 → only addr 0x000002 is written, ack at edge 4. Read with sel=4'b0110 → o_wb_dat=0x00EE_xx00 (lane 1 holds memory content), ack at edge 8.
- Empty select: sel=4'b0000 → no cs or strobe activity, ack in the cycle after edge 0.
- SRAM_WR_POSTED_EN: write 0x11223344 then an immediate read of the same address → write acked after edge 0; read ack follows write completion plus 16 cycles; read returns 0x11223344.
